// File: rtl/wishbone_decoder_if.sv
// Wishbone bus bundle seen by the address decoder: upstream master side plus
// the per-slot fan-out towards the peripherals.
interface wishbone_decoder_if #(
    parameter int SLAVES_WIDTH  = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int SLAVES_COUNT = 1 << SLAVES_WIDTH;

    logic                               mCycI;
    logic                               mStbI;
    logic                               mWeI;
    logic [ADDRESS_WIDTH-1:0]           mAdrI;
    logic [DATA_WIDTH-1:0]              mDatI;
    logic [DATA_WIDTH-1:0]              mDatO;
    logic                               mAckO;
    logic                               mErrO;
    logic [SLAVES_COUNT-1:0]            sCycO;
    logic [SLAVES_COUNT-1:0]            sStbO;
    logic                               sWeO;
    logic [ADDRESS_WIDTH-1:0]           sAdrO;
    logic [DATA_WIDTH-1:0]              sDatO;
    logic [SLAVES_COUNT-1:0]            sAckI;
    logic [DATA_WIDTH*SLAVES_COUNT-1:0] sDatIPacked;

    // The decoder itself: a slave towards the master, fanning out to the peripherals.
    modport slave (
        input  mCycI, mStbI, mWeI, mAdrI, mDatI,
        output mDatO, mAckO, mErrO,
        output sCycO, sStbO, sWeO, sAdrO, sDatO,
        input  sAckI, sDatIPacked
    );

    // The surrounding environment: master plus peripherals.
    modport master (
        output mCycI, mStbI, mWeI, mAdrI, mDatI,
        input  mDatO, mAckO, mErrO,
        input  sCycO, sStbO, sWeO, sAdrO, sDatO,
        output sAckI, sDatIPacked
    );
endinterface

// File: rtl/wishbone_decoder.sv
// Single-master to multi-slave Wishbone address decoder. The slot is picked from
// the top address bits, locked for the whole master cycle, with timeout/unmapped errors.
//
// state | meaning
// IDLE  | no slave selected, waiting for a master strobe to decode
// CYCLE | slot sel locked, cyc/stb routed to it until mCycI falls
// ERROR | unmapped slot or wait-state timeout, err returned for one clk
module wishbone_decoder #(
    parameter int                            SLAVES_WIDTH   = 2,
    parameter int                            ADDRESS_WIDTH  = 32,
    parameter int                            DATA_WIDTH     = 32,
    parameter logic [(1<<SLAVES_WIDTH)-1:0]  SLAVE_MASK     = '1,
    parameter int                            TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    wishbone_decoder_if.slave  bus
);
    localparam int SLAVES_COUNT = 1 << SLAVES_WIDTH;
    localparam int CNT_WIDTH    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t                  state, stateNext;
    logic [SLAVES_WIDTH-1:0] sel, selNext;
    logic [CNT_WIDTH-1:0]    waitCnt, waitCntNext;
    logic [SLAVES_WIDTH-1:0] adrSlot;
    logic                    selAck;
    logic                    timeout;

    assign adrSlot   = bus.mAdrI[ADDRESS_WIDTH-1 -: SLAVES_WIDTH];
    assign selAck    = bus.sAckI[sel];
    // An ack in the expiry cycle masks the timeout, so the ack always wins.
    assign timeout   = (TIMEOUT_CYCLES != 0) && bus.mStbI && !selAck && (waitCnt == CNT_LAST);

    assign bus.sWeO  = bus.mWeI;
    assign bus.sAdrO = bus.mAdrI;
    assign bus.sDatO = bus.mDatI;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            sel     <= selNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        selNext     = sel;
        waitCntNext = waitCnt;
        bus.sCycO   = '0;
        bus.sStbO   = '0;
        bus.mAckO   = 1'b0;
        bus.mErrO   = 1'b0;
        bus.mDatO   = '0;
        case (state)
            IDLE: begin
                if (bus.mCycI && bus.mStbI) begin
                    selNext     = adrSlot;
                    waitCntNext = '0;
                    stateNext   = SLAVE_MASK[adrSlot] ? CYCLE : ERROR;
                end
            end
            CYCLE: begin
                bus.sCycO[sel] = bus.mCycI;
                bus.sStbO[sel] = bus.mStbI;
                bus.mAckO      = selAck && bus.mStbI;
                bus.mDatO      = bus.sDatIPacked[DATA_WIDTH*int'(sel) +: DATA_WIDTH];
                waitCntNext    = (bus.mStbI && !selAck) ? waitCnt + 1'b1 : '0;
                if (!bus.mCycI) begin
                    stateNext = IDLE;
                end else if (timeout) begin
                    stateNext = ERROR;
                end
            end
            ERROR: begin
                bus.mErrO = bus.mCycI && bus.mStbI;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_wishbone_decoder.sv
// Scoreboard bench for wishbone_decoder: directed master accesses push expected
// ack/err responses; a negedge monitor pops and compares them.
module tb_wishbone_decoder;
    localparam int SW = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SC = 1 << SW;

    typedef struct {
        bit          isErr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wishbone_decoder_if #(.SLAVES_WIDTH(SW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    wishbone_decoder #(
        .SLAVES_WIDTH(SW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_MASK(4'b0111), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       ackSeen = 0;
    int       errSeen = 0;
    exp_t     expQ[$];
    exp_t     monE;
    logic [SC-1:0] allowedMask = '0;

    // Slave models: slot i acks once it has waited delayCfg[i] strobe cycles.
    int delayCfg[SC];
    int waitN[SC];
    logic [31:0] slotData[SC];

    initial begin
        slotData[0] = 32'hA0A0A0A0;
        slotData[1] = 32'hDEADBEEF;
        slotData[2] = 32'hCAFEF00D;
        slotData[3] = 32'h33333333;
        for (int i = 0; i < SC; i++) delayCfg[i] = 0;
    end

    assign bus.sDatIPacked = {slotData[3], slotData[2], slotData[1], slotData[0]};

    always_comb begin
        bus.sAckI = '0;
        for (int i = 0; i < SC; i++)
            bus.sAckI[i] = bus.sCycO[i] && bus.sStbO[i] && (waitN[i] >= delayCfg[i]);
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < SC; i++) begin
            if (rst) waitN[i] <= 0;
            else if (bus.sStbO[i] && !bus.sAckI[i]) waitN[i] <= waitN[i] + 1;
            else waitN[i] <= 0;
        end
    end

    // Monitor: response scoreboard plus bus invariants.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(bus.sCycO) > 1 || (bus.mAckO && bus.mErrO) ||
                (bus.sCycO & ~allowedMask) != '0) begin
                errors++;
                $display("FAIL invariant: sCycO=%b ack=%b err=%b allowed=%b",
                         bus.sCycO, bus.mAckO, bus.mErrO, allowedMask);
            end
            if (bus.mAckO || bus.mErrO) begin
                if (bus.mAckO) ackSeen++;
                if (bus.mErrO) errSeen++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: ack=%b err=%b, none required",
                             bus.mAckO, bus.mErrO);
                end else begin
                    monE = expQ.pop_front();
                    if (monE.isErr != bus.mErrO || (!monE.isErr && bus.mDatO !== monE.data)) begin
                        errors++;
                        $display("FAIL resp: got err=%b data=%h, required err=%b data=%h",
                                 bus.mErrO, bus.mDatO, monE.isErr, monE.data);
                    end
                end
            end
        end
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushExp(input bit isErr, input logic [31:0] data);
        exp_t e;
        e.isErr = isErr;
        e.data  = data;
        expQ.push_back(e);
    endtask

    task automatic startAccess(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        bus.mCycI = 1'b1;
        bus.mStbI = 1'b1;
        bus.mWeI  = we;
        bus.mAdrI = adr;
        bus.mDatI = dat;
    endtask

    task automatic dropMaster();
        bus.mCycI = 1'b0;
        bus.mStbI = 1'b0;
        bus.mWeI  = 1'b0;
    endtask

    // Waits (bounded) for ack or err; returns negedges waited and how many had a slave cyc up.
    task automatic waitResp(input int budget, output int cycles, output int selCycles);
        bit done;
        done = 0;
        cycles = 0;
        selCycles = 0;
        while (!done) begin
            @(negedge clk);
            cycles++;
            if (bus.sCycO != '0) selCycles++;
            if (bus.mAckO || bus.mErrO) begin
                done = 1;
            end else if (cycles >= budget) begin
                checks++;
                errors++;
                $display("FAIL resp_wait: no ack/err after %0d cycles", cycles);
                done = 1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, selCyc, ack0, err0;
        bus.mCycI = 1'b0;
        bus.mStbI = 1'b0;
        bus.mWeI  = 1'b0;
        bus.mAdrI = '0;
        bus.mDatI = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("reset_sCyc", 32'(bus.sCycO), 32'h0);
        checkEq("reset_ackerr", {30'd0, bus.mAckO, bus.mErrO}, 32'h0);
        rst = 1'b0;

        // Read from slot 1 with a zero-wait slave.
        allowedMask = 4'b0010;
        delayCfg[1] = 0;
        pushExp(1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        startAccess(32'h4000_0010, 32'h0, 1'b0);
        waitResp(10, cyc, selCyc);
        checkEq("t1_latency", cyc, 2);
        checkEq("t1_sCyc", 32'(bus.sCycO), 32'h2);
        @(posedge clk); #1;
        dropMaster();

        // Three writes in one cycle; the middle address points at slot 3 but stays locked to slot 1.
        ack0 = ackSeen;
        for (int k = 0; k < 3; k++) pushExp(1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        startAccess(32'h4000_0000, 32'h1111_1111, 1'b1);
        waitResp(10, cyc, selCyc);
        checkEq("t2_first_latency", cyc, 2);
        @(posedge clk); #1;
        bus.mAdrI = 32'hC000_0004;
        bus.mDatI = 32'h2222_2222;
        waitResp(10, cyc, selCyc);
        checkEq("t2_second_latency", cyc, 1);
        checkEq("t2_sCyc_locked", 32'(bus.sCycO), 32'h2);
        checkEq("t2_sAdr_pass", bus.sAdrO, 32'hC000_0004);
        checkEq("t2_sDat_pass", bus.sDatO, 32'h2222_2222);
        checkEq("t2_sWe_pass", 32'(bus.sWeO), 32'h1);
        @(posedge clk); #1;
        bus.mAdrI = 32'h4000_0008;
        bus.mDatI = 32'h3333_3333;
        waitResp(10, cyc, selCyc);
        checkEq("t2_third_latency", cyc, 1);
        checkEq("t2_sCyc_third", 32'(bus.sCycO), 32'h2);
        @(posedge clk); #1;
        dropMaster();
        @(negedge clk);
        checkEq("t2_sCyc_after", 32'(bus.sCycO), 32'h0);
        checkEq("t2_ack_count", ackSeen - ack0, 3);

        // Unmapped slot 3.
        allowedMask = 4'b0000;
        err0 = errSeen;
        pushExp(1'b1, 32'h0);
        @(posedge clk); #1;
        startAccess(32'hC000_0000, 32'h0, 1'b0);
        waitResp(10, cyc, selCyc);
        checkEq("t3_err_latency", cyc, 2);
        checkEq("t3_no_sCyc", selCyc, 0);
        @(posedge clk); #1;
        dropMaster();
        @(negedge clk);
        checkEq("t3_err_once", errSeen - err0, 1);

        // Slot 2 never acks: timeout after 4 wait cycles.
        allowedMask = 4'b0100;
        delayCfg[2] = 1000;
        ack0 = ackSeen;
        pushExp(1'b1, 32'h0);
        @(posedge clk); #1;
        startAccess(32'h8000_0000, 32'h0, 1'b0);
        waitResp(20, cyc, selCyc);
        checkEq("t4_err_latency", cyc, 6);
        checkEq("t4_sCyc_cycles", selCyc, 4);
        checkEq("t4_no_ack", ackSeen - ack0, 0);
        @(posedge clk); #1;
        dropMaster();

        // Slot 2 acks exactly on the expiry cycle: ack wins.
        delayCfg[2] = 3;
        err0 = errSeen;
        pushExp(1'b0, 32'hCAFEF00D);
        @(posedge clk); #1;
        startAccess(32'h8000_0020, 32'h0, 1'b0);
        waitResp(20, cyc, selCyc);
        checkEq("t5_ack_latency", cyc, 5);
        checkEq("t5_sCyc_cycles", selCyc, 4);
        @(posedge clk); #1;
        dropMaster();
        @(negedge clk);
        checkEq("t5_no_err", errSeen - err0, 0);
        checkEq("t5_sCyc_after", 32'(bus.sCycO), 32'h0);

        // Asynchronous reset in the middle of a slot 0 cycle.
        allowedMask = 4'b0001;
        delayCfg[0] = 1000;
        @(posedge clk); #1;
        startAccess(32'h0000_0000, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkEq("t6_sCyc_before", 32'(bus.sCycO), 32'h1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkEq("t6_sCyc_rst", 32'(bus.sCycO), 32'h0);
        checkEq("t6_sStb_rst", 32'(bus.sStbO), 32'h0);
        checkEq("t6_ackerr_rst", {30'd0, bus.mAckO, bus.mErrO}, 32'h0);
        dropMaster();
        allowedMask = 4'b0010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fresh access after reset decodes normally.
        pushExp(1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        startAccess(32'h4000_0010, 32'h0, 1'b0);
        waitResp(10, cyc, selCyc);
        checkEq("t7_latency", cyc, 2);
        checkEq("t7_sCyc", 32'(bus.sCycO), 32'h2);
        @(posedge clk); #1;
        dropMaster();
        repeat (2) @(negedge clk);

        checkEq("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
